mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single main-memory RAM port between two cache controllers (instruction-side port 0, data-side port 1). It sits between the controllers' `mem_*` handshake outputs and the RAM's write_en/read_en/addr/data_in/data_out/ack interface. Each requester sees the arbiter as a private RAM. The arbiter serialises accesses with round-robin fairness and a watchdog timeout so that a lost acknowledge cannot hang the system.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one RAM port between the instruction-side (0)
// and data-side (1) cache controllers, with a watchdog that aborts a lost acknowledge.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_data_in,
    input  logic                  p0_wen,
    input  logic                  p0_ren,
    output logic [DATA_WIDTH-1:0] p0_data_out,
    output logic                  p0_ready,
    output logic                  p0_err,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_data_in,
    input  logic                  p1_wen,
    input  logic                  p1_ren,
    output logic [DATA_WIDTH-1:0] p1_data_out,
    output logic                  p1_ready,
    output logic                  p1_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic                  mem_ready,
    output logic                  grant,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic          rr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          req0;
    logic          req1;
    logic          win;

    // A lone requester wins outright; rr only breaks ties.
    always_comb begin
        req0    = p0_wen | p0_ren;
        req1    = p1_wen | p1_ren;
        win     = (req0 && req1) ? rr : req1;
        cnt_inc = cnt + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // reads the pre-edge values of state, cnt, grant and the strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            cnt         <= '0;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            p0_ready    <= 1'b0;
            p0_err      <= 1'b0;
            p0_data_out <= '0;
            p1_ready    <= 1'b0;
            p1_err      <= 1'b0;
            p1_data_out <= '0;
            grant       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            p0_ready <= 1'b0;
            p0_err   <= 1'b0;
            p1_ready <= 1'b0;
            p1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant <= win;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= BUSY;
                        // Write takes precedence when both wen and ren are high.
                        if (win) begin
                            mem_addr    <= p1_addr;
                            mem_data_in <= p1_data_in;
                            mem_wen     <= p1_wen;
                            mem_ren     <= p1_ren & ~p1_wen;
                        end else begin
                            mem_addr    <= p0_addr;
                            mem_data_in <= p0_data_in;
                            mem_wen     <= p0_wen;
                            mem_ren     <= p0_ren & ~p0_wen;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_inc;
                    if (mem_ready || cnt_inc == CW'(TIMEOUT)) begin
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        busy    <= 1'b0;
                        rr      <= ~grant;
                        state   <= DONE;
                        if (grant) begin
                            p1_ready <= 1'b1;
                            p1_err   <= ~mem_ready;
                            if (mem_ready && mem_ren)
                                p1_data_out <= mem_data_out;
                        end else begin
                            p0_ready <= 1'b1;
                            p0_err   <= ~mem_ready;
                            if (mem_ready && mem_ren)
                                p0_data_out <= mem_data_out;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8): single access, tie-break, round robin,
// write precedence, watchdog abort and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] p0_addr, p1_addr, mem_addr;
    logic [31:0] p0_data_in, p1_data_in, p0_data_out, p1_data_out;
    logic [31:0] mem_data_in, mem_data_out;
    logic        p0_wen, p0_ren, p0_ready, p0_err;
    logic        p1_wen, p1_ren, p1_ready, p1_err;
    logic        mem_wen, mem_ren, mem_ready, grant, busy;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_data_in(p0_data_in), .p0_wen(p0_wen), .p0_ren(p0_ren),
        .p0_data_out(p0_data_out), .p0_ready(p0_ready), .p0_err(p0_err),
        .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_wen(p1_wen), .p1_ren(p1_ren),
        .p1_data_out(p1_data_out), .p1_ready(p1_ready), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_ready(mem_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        p0_addr = '0; p0_data_in = '0; p0_wen = 0; p0_ren = 0;
        p1_addr = '0; p1_data_in = '0; p1_wen = 0; p1_ren = 0;
        mem_data_out = '0; mem_ready = 0;
        tick(); tick();
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_mem_ren", mem_ren, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_grant", grant, 0);
        check("rst_p0_ready", p0_ready, 0);
        check("rst_p0_data_out", p0_data_out, 0);

        // Port 0 read of 0x0010, RAM acks on the second BUSY cycle
        p0_ren = 1; p0_addr = 16'h0010;
        tick();
        check("t1_busy", busy, 1);
        check("t1_mem_ren_c1", mem_ren, 1);
        check("t1_mem_addr", mem_addr, 32'h0010);
        check("t1_grant", grant, 0);
        tick();
        check("t1_mem_ren_c2", mem_ren, 1);
        mem_ready = 1; mem_data_out = 32'hDEADBEEF;
        tick();
        mem_ready = 0; p0_ren = 0;
        check("t1_p0_ready", p0_ready, 1);
        check("t1_p0_data", p0_data_out, 32'hDEADBEEF);
        check("t1_p0_err", p0_err, 0);
        check("t1_p1_ready", p1_ready, 0);
        check("t1_mem_ren_low", mem_ren, 0);
        check("t1_busy_low", busy, 0);
        tick();
        check("t1_p0_ready_pulse", p0_ready, 0);

        // mem_ready while idle is ignored
        mem_ready = 1;
        tick();
        mem_ready = 0;
        check("idle_ack_busy", busy, 0);
        check("idle_ack_p0_ready", p0_ready, 0);
        check("idle_ack_p1_ready", p1_ready, 0);

        // Simultaneous requests right after reset: port 0 first, then port 1
        rst = 1; tick(); rst = 0;
        p0_ren = 1; p0_addr = 16'h0100;
        p1_wen = 1; p1_addr = 16'h0200; p1_data_in = 32'h12345678;
        tick();
        check("t2_grant0", grant, 0);
        check("t2_mem_ren", mem_ren, 1);
        check("t2_mem_addr0", mem_addr, 32'h0100);
        mem_ready = 1; mem_data_out = 32'hCAFEF00D;
        tick();
        mem_ready = 0; p0_ren = 0;
        check("t2_p0_ready", p0_ready, 1);
        check("t2_p0_data", p0_data_out, 32'hCAFEF00D);
        tick();
        check("t2_done_busy", busy, 0);
        tick();
        check("t2_busy1", busy, 1);
        check("t2_grant1", grant, 1);
        check("t2_mem_wen", mem_wen, 1);
        check("t2_mem_ren1", mem_ren, 0);
        check("t2_mem_data_in", mem_data_in, 32'h12345678);
        check("t2_mem_addr1", mem_addr, 32'h0200);
        mem_ready = 1; mem_data_out = 32'hFFFF0000;
        tick();
        mem_ready = 0; p1_wen = 0;
        check("t2_p1_ready", p1_ready, 1);
        check("t2_p1_err", p1_err, 0);
        check("t2_p1_data_hold", p1_data_out, 0);
        tick();

        // Continuous requests from both ports alternate the grant
        p0_ren = 1; p1_ren = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), grant, i % 2);
            mem_ready = 1; mem_data_out = 32'h100 + i;
            tick();
            mem_ready = 0;
            check($sformatf("rr_p0_ready%0d", i), p0_ready, (i % 2 == 0));
            check($sformatf("rr_p1_ready%0d", i), p1_ready, (i % 2 == 1));
            tick();
        end
        p0_ren = 0; p1_ren = 0;
        check("rr_p0_data", p0_data_out, 32'h104);
        check("rr_p1_data", p1_data_out, 32'h105);

        // Port 0 read leaves rr pointing at port 1
        p0_ren = 1; p0_addr = 16'h0300;
        tick();
        mem_ready = 1; mem_data_out = 32'h0BADF00D;
        tick();
        mem_ready = 0; p0_ren = 0;
        check("pre_to_p0_ready", p0_ready, 1);
        tick();

        // Port 1 write+read -> write; RAM never acks -> abort after 8 BUSY cycles
        p1_wen = 1; p1_ren = 1; p1_addr = 16'h0400; p1_data_in = 32'hA5A5A5A5;
        tick();
        check("wr_pri_mem_wen", mem_wen, 1);
        check("wr_pri_mem_ren", mem_ren, 0);
        check("wr_pri_grant", grant, 1);
        for (int k = 1; k < 8; k++) tick();
        check("to_p1_ready_early", p1_ready, 0);
        check("to_busy_c7", busy, 1);
        tick();
        check("to_p1_ready", p1_ready, 1);
        check("to_p1_err", p1_err, 1);
        check("to_mem_wen_low", mem_wen, 0);
        check("to_busy_low", busy, 0);
        check("to_p1_data_hold", p1_data_out, 32'h105);
        p1_wen = 0; p1_ren = 0;
        tick();
        check("to_p1_ready_pulse", p1_ready, 0);

        // After the timeout, rr favours port 0 on a tie
        p0_ren = 1; p0_addr = 16'h0500; p1_ren = 1;
        tick();
        check("to_rr_grant", grant, 0);
        check("to_rr_mem_ren", mem_ren, 1);

        // Reset during BUSY: strobes drop, no ready pulse
        rst = 1;
        tick();
        rst = 0; p1_ren = 0; p0_addr = 16'h0600;
        check("rst_mid_mem_ren", mem_ren, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_p0_ready", p0_ready, 0);
        check("rst_mid_p1_ready", p1_ready, 0);
        check("rst_mid_p0_data", p0_data_out, 0);
        tick();
        check("post_rst_busy", busy, 1);
        check("post_rst_addr", mem_addr, 32'h0600);
        check("post_rst_p0_ready", p0_ready, 0);
        mem_ready = 1; mem_data_out = 32'h5A5AA5A5;
        tick();
        mem_ready = 0; p0_ren = 0;
        check("post_rst_p0_ready_hi", p0_ready, 1);
        check("post_rst_p0_err", p0_err, 0);
        check("post_rst_p0_data", p0_data_out, 32'h5A5AA5A5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
